// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two requesters share one single-port memory.
// Round-robin grant, IDLE -> MEM -> RESP sequencing, RISC-V lane enables,
// load extraction with sign/zero extension, and misaligned-access rejection.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; grant is issued combinationally here
// MEM   | memory strobe for the accepted access (suppressed on error)
// RESP  | completion pulse and formatted load data to the owner
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_size,
    input  logic              req0_unsigned,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_gnt,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_size,
    input  logic              req1_unsigned,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_gnt,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_owner_q;
    logic              owner_q;
    logic              we_q;
    logic [MEM_AW+1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              any_gnt;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_err;
    logic              unused_addr_bits;

    logic              in_access;
    logic              in_resp;
    logic [3:0]        be_lanes;
    logic [DATA_W-1:0] wdata_lanes;
    logic [DATA_W-1:0] lane_shift;
    logic [DATA_W-1:0] load_fmt;
    logic [DATA_W-1:0] rdata_out;

    // Round-robin grant: a lone requester wins; on a tie the port that did not own last wins.
    // Grant is held off while reset is asserted so nothing is accepted into a resetting FSM.
    always_comb begin
        req0_gnt = 1'b0;
        req1_gnt = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (req0_valid && (!req1_valid || last_owner_q)) begin
                req0_gnt = 1'b1;
            end else if (req1_valid) begin
                req1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt  = req0_gnt | req1_gnt;
    assign sel      = req1_gnt;
    assign sel_addr = sel ? req1_addr : req0_addr;
    assign sel_size = sel ? req1_size : req0_size;
    assign sel_err  = (sel_size == 2'd3)
                    | (sel_size == 2'd1 &&  sel_addr[0])
                    | (sel_size == 2'd2 && (sel_addr[1:0] != 2'b00));

    // Byte-address bits above the memory word range do not reach the memory.
    assign unused_addr_bits = ^sel_addr[ADDR_W-1:MEM_AW+2];

    // Next-state: every non-idle state advances unconditionally.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = any_gnt ? S_MEM : S_IDLE;
            S_MEM:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, arbitration history and the captured request of the current access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (any_gnt) begin
                last_owner_q <= sel;
                owner_q      <= sel;
                we_q         <= sel ? req1_we : req0_we;
                addr_q       <= sel_addr[MEM_AW+1:0];
                size_q       <= sel_size;
                uns_q        <= sel ? req1_unsigned : req0_unsigned;
                wdata_q      <= sel ? req1_wdata : req0_wdata;
                err_q        <= sel_err;
            end
        end
    end

    // Lane enables and lane-replicated store data for the captured access.
    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = wdata_q;
        case (size_q)
            2'd0: begin
                be_lanes    = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = wdata_q;
            end
        endcase
    end

    // An erroring access never strobes memory; all memory outputs are quiet outside MEM.
    assign in_access = (state_q == S_MEM) && !err_q;
    assign in_resp   = (state_q == S_RESP);
    assign mem_en    = in_access;
    assign mem_we    = in_access & we_q;
    assign mem_be    = in_access ? be_lanes : 4'b0000;
    assign mem_addr  = in_access ? addr_q[MEM_AW+1:2] : '0;
    assign mem_wdata = in_access ? wdata_lanes : '0;

    // Load formatting: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    load_fmt = {{24{~uns_q & lane_shift[7]}},  lane_shift[7:0]};
            2'd1:    load_fmt = {{16{~uns_q & lane_shift[15]}}, lane_shift[15:0]};
            default: load_fmt = lane_shift;
        endcase
    end

    assign rdata_out   = (in_resp && !we_q && !err_q) ? load_fmt : '0;
    assign req0_rvalid = in_resp & ~owner_q;
    assign req1_rvalid = in_resp &  owner_q;
    assign req0_err    = req0_rvalid & err_q;
    assign req1_err    = req1_rvalid & err_q;
    assign req0_rdata  = req0_rvalid ? rdata_out : '0;
    assign req1_rdata  = req1_rvalid ? rdata_out : '0;

endmodule
